mu0_sequencer: RTL and testbench

Timing-state generator for the MU0 datapath. It produces the one-hot fetch/exec1/exec2 phase strobes consumed by the instruction decoder. It sequences each instruction through two or three cycles, using the decoder's extra-cycle flag and the current opcode. It also provides sticky halt on STP, free-run/single-step control, and retired-instruction and cycle counters for the board display.

---
 rtl/mu0_pkg.sv | 27 ++
 rtl/mu0_sequencer_step_sync.sv | 27 ++
 rtl/mu0_sequencer.sv | 93 +++++++++
 tb/tb_mu0_sequencer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mu0_pkg.sv
// Shared MU0 definitions: sequencer state encoding, opcode map and counter width.
package mu0_pkg;

  localparam int DEF_CNT_W = 16;

  // Registered one-hot so every phase strobe is a single flop output.
  typedef enum logic [4:0] {
    FETCH = 5'b00001,
    EXEC1 = 5'b00010,
    EXEC2 = 5'b00100,
    PAUSE = 5'b01000,
    HALT  = 5'b10000
  } state_e;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_STA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_JMP = 4'b0100;
  localparam logic [3:0] OP_JGE = 4'b0101;
  localparam logic [3:0] OP_JNE = 4'b0110;
  localparam logic [3:0] OP_STP = 4'b0111;
  localparam logic [3:0] OP_AND = 4'b1000;
  localparam logic [3:0] OP_LSL = 4'b1001;
  localparam logic [3:0] OP_LSR = 4'b1010;

endpackage

// File: rtl/mu0_sequencer_step_sync.sv
// Step push-button synchroniser followed by a one-cycle rising-edge detector.
module step_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic step_btn,
  output logic step_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], step_btn};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // A held button yields one pulse: only the 0->1 change of the synced level fires.
  assign step_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/mu0_sequencer.sv
// MU0 timing-state generator: fetch/exec1/exec2 phase strobes, sticky halt,
// single-step control and retired-instruction / active-cycle counters.
module mu0_sequencer
  import mu0_pkg::*;
#(
  parameter int         CNT_W       = DEF_CNT_W,
  parameter logic [3:0] STP_OPCODE  = OP_STP,
  parameter int         SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       op,
  input  logic             extra,
  input  logic             step_mode,
  input  logic             step_btn,
  output logic             fetch,
  output logic             exec1,
  output logic             exec2,
  output logic             halted,
  output logic             paused,
  output logic [CNT_W-1:0] retired_count,
  output logic [CNT_W-1:0] cycle_count
);

  state_e           state_q, state_d;
  logic             step_pulse;
  logic             retire;
  logic [CNT_W-1:0] retired_q, cycle_q;

  step_sync #(.SYNC_STAGES(SYNC_STAGES)) u_step_sync (
    .clk        (clk),
    .reset      (reset),
    .step_btn   (step_btn),
    .step_pulse (step_pulse)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Step pulses outside PAUSE are simply not looked at, so they are dropped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH: state_d = EXEC1;
      EXEC1: begin
        if (op == STP_OPCODE) state_d = HALT;
        else if (extra)       state_d = EXEC2;
        else if (step_mode)   state_d = PAUSE;
        else                  state_d = FETCH;
      end
      EXEC2: state_d = step_mode ? PAUSE : FETCH;
      PAUSE: if (!step_mode || step_pulse) state_d = FETCH;
      HALT:  state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    fetch  = 1'b0;
    exec1  = 1'b0;
    exec2  = 1'b0;
    paused = 1'b0;
    halted = 1'b0;
    unique case (state_q)
      FETCH:   fetch  = 1'b1;
      EXEC1:   exec1  = 1'b1;
      EXEC2:   exec2  = 1'b1;
      PAUSE:   paused = 1'b1;
      HALT:    halted = 1'b1;
      default: ;
    endcase
  end

  // An instruction retires on its last execute cycle; STP never completes.
  assign retire = (state_q == EXEC2) ||
                  (state_q == EXEC1 && op != STP_OPCODE && !extra);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_q <= '0;
      cycle_q   <= '0;
    end else begin
      if (retire) retired_q <= retired_q + CNT_W'(1);
      if (fetch || exec1 || exec2) cycle_q <= cycle_q + CNT_W'(1);
    end
  end

  assign retired_count = retired_q;
  assign cycle_count   = cycle_q;

endmodule

// File: tb/tb_mu0_sequencer.sv
// Directed bench for mu0_sequencer: vector table for free-run/step-mode phases,
// hand sequences for step button, halt, async reset and counter wrap.
module tb_mu0_sequencer;

  localparam logic [4:0] S_F  = 5'b10000;
  localparam logic [4:0] S_E1 = 5'b01000;
  localparam logic [4:0] S_E2 = 5'b00100;
  localparam logic [4:0] S_P  = 5'b00010;
  localparam logic [4:0] S_H  = 5'b00001;

  logic        clk, reset;
  logic [3:0]  op;
  logic        extra, step_mode, step_btn;
  logic        fetch, exec1, exec2, halted, paused;
  logic [15:0] retired_count, cycle_count;
  logic        w_fetch, w_exec1, w_exec2, w_halted, w_paused;
  logic [3:0]  w_retired, w_cycle;

  int n_chk  = 0;
  int n_fail = 0;

  mu0_sequencer dut (
    .clk(clk), .reset(reset), .op(op), .extra(extra), .step_mode(step_mode),
    .step_btn(step_btn), .fetch(fetch), .exec1(exec1), .exec2(exec2),
    .halted(halted), .paused(paused), .retired_count(retired_count),
    .cycle_count(cycle_count)
  );

  mu0_sequencer #(.CNT_W(4)) dut_w (
    .clk(clk), .reset(reset), .op(op), .extra(extra), .step_mode(step_mode),
    .step_btn(step_btn), .fetch(w_fetch), .exec1(w_exec1), .exec2(w_exec2),
    .halted(w_halted), .paused(w_paused), .retired_count(w_retired),
    .cycle_count(w_cycle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] strobes();
    return {fetch, exec1, exec2, paused, halted};
  endfunction

  typedef struct {
    logic [3:0]  op;
    logic        extra;
    logic        sm;
    logic [4:0]  st;
    logic [15:0] ret;
    logic [15:0] cyc;
  } vec_t;

  vec_t vt[22];

  initial begin
    vt[0]  = '{4'd1, 1'b0, 1'b0, S_F,  16'd0, 16'd0};
    vt[1]  = '{4'd1, 1'b0, 1'b0, S_E1, 16'd0, 16'd1};
    vt[2]  = '{4'd1, 1'b0, 1'b0, S_F,  16'd1, 16'd2};
    vt[3]  = '{4'd1, 1'b0, 1'b0, S_E1, 16'd1, 16'd3};
    vt[4]  = '{4'd2, 1'b1, 1'b0, S_F,  16'd2, 16'd4};
    vt[5]  = '{4'd2, 1'b1, 1'b0, S_E1, 16'd2, 16'd5};
    vt[6]  = '{4'd7, 1'b1, 1'b0, S_E2, 16'd2, 16'd6};
    vt[7]  = '{4'd7, 1'b1, 1'b0, S_F,  16'd3, 16'd7};
    vt[8]  = '{4'd2, 1'b1, 1'b0, S_E1, 16'd3, 16'd8};
    vt[9]  = '{4'd7, 1'b0, 1'b0, S_E2, 16'd3, 16'd9};
    vt[10] = '{4'd1, 1'b0, 1'b1, S_F,  16'd4, 16'd10};
    vt[11] = '{4'd1, 1'b0, 1'b1, S_E1, 16'd4, 16'd11};
    vt[12] = '{4'd1, 1'b0, 1'b1, S_P,  16'd5, 16'd12};
    vt[13] = '{4'd1, 1'b0, 1'b0, S_P,  16'd5, 16'd12};
    vt[14] = '{4'd1, 1'b0, 1'b0, S_F,  16'd5, 16'd12};
    vt[15] = '{4'd1, 1'b0, 1'b0, S_E1, 16'd5, 16'd13};
    vt[16] = '{4'd2, 1'b1, 1'b0, S_F,  16'd6, 16'd14};
    vt[17] = '{4'd2, 1'b1, 1'b1, S_E1, 16'd6, 16'd15};
    vt[18] = '{4'd2, 1'b1, 1'b1, S_E2, 16'd6, 16'd16};
    vt[19] = '{4'd2, 1'b1, 1'b0, S_P,  16'd7, 16'd17};
    vt[20] = '{4'd1, 1'b0, 1'b1, S_F,  16'd7, 16'd17};
    vt[21] = '{4'd1, 1'b0, 1'b1, S_E1, 16'd7, 16'd18};

    reset = 1'b1; op = 4'd0; extra = 1'b0; step_mode = 1'b0; step_btn = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_strobes", strobes(), S_F);
    chk("reset_ret", retired_count, 0);
    chk("reset_cyc", cycle_count, 0);
    reset = 1'b0;

    // Table: inputs set here act at the next edge; outputs reflect current state.
    for (int i = 0; i < 22; i++) begin
      if (i > 0) @(negedge clk);
      op = vt[i].op; extra = vt[i].extra; step_mode = vt[i].sm;
      chk($sformatf("vec%0d_strobes", i), strobes(), vt[i].st);
      chk($sformatf("vec%0d_ret", i), retired_count, vt[i].ret);
      chk($sformatf("vec%0d_cyc", i), cycle_count, vt[i].cyc);
    end

    // Step button held 10 cycles while paused: exactly one fetch/exec1 pair.
    @(negedge clk);
    chk("step_paused", strobes(), S_P);
    chk("step_ret0", retired_count, 8);
    chk("step_cyc0", cycle_count, 19);
    step_btn = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 9) step_btn = 1'b0;
      chk($sformatf("step_k%0d", k), strobes(),
          (k == 2) ? S_F : (k == 3) ? S_E1 : S_P);
    end
    chk("step_ret1", retired_count, 9);
    chk("step_cyc1", cycle_count, 21);

    // STP with extra forced: halt wins, counters and button frozen out.
    step_mode = 1'b0;
    @(negedge clk);
    chk("stp_fetch", strobes(), S_F);
    op = 4'b0111; extra = 1'b1;
    @(negedge clk);
    chk("stp_exec1", strobes(), S_E1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      step_btn = ~step_btn;
      op = 4'd1; extra = 1'b0;
      chk($sformatf("halt_k%0d", k), strobes(), S_H);
    end
    chk("halt_ret", retired_count, 9);
    chk("halt_cyc", cycle_count, 23);

    // Asynchronous reset out of HALT, checked before any clock edge.
    #2 reset = 1'b1;
    #1;
    chk("rst_halt_strobes", strobes(), S_F);
    chk("rst_halt_ret", retired_count, 0);
    chk("rst_halt_cyc", cycle_count, 0);
    step_btn = 1'b0;
    @(negedge clk);
    reset = 1'b0; op = 4'd2; extra = 1'b1;
    @(negedge clk);
    chk("rst2_exec1", strobes(), S_E1);
    @(negedge clk);
    chk("rst2_exec2", strobes(), S_E2);
    chk("rst2_cyc", cycle_count, 2);
    #2 reset = 1'b1;
    #1;
    chk("rst_exec2_strobes", strobes(), S_F);
    chk("rst_exec2_ret", retired_count, 0);
    chk("rst_exec2_cyc", cycle_count, 0);
    @(negedge clk);
    reset = 1'b0; op = 4'd1; extra = 1'b0;

    // Narrow counters wrap to 0 after 16 instructions with clean strobes.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("wrap%0d_e1", i), {w_fetch, w_exec1, w_exec2, w_paused, w_halted}, S_E1);
      chk($sformatf("wrap%0d_ret_a", i), w_retired, i % 16);
      chk($sformatf("wrap%0d_cyc_a", i), w_cycle, (2 * i + 1) % 16);
      @(negedge clk);
      chk($sformatf("wrap%0d_f", i), {w_fetch, w_exec1, w_exec2, w_paused, w_halted}, S_F);
      chk($sformatf("wrap%0d_ret_b", i), w_retired, (i + 1) % 16);
      chk($sformatf("wrap%0d_cyc_b", i), w_cycle, (2 * i + 2) % 16);
    end
    chk("wrap_main_ret", retired_count, 16);
    chk("wrap_main_cyc", cycle_count, 32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
